// File: rtl/out_buff_pkg.sv
//------------------------------------------------------------------------------
// out_buff_pkg
//   Constants and types shared by the SFU datapath buffers.
//
//   SFU_IN_LANES   : lanes in a full SFU word (input buffer side / out_buff output)
//   SFU_CORE_LANES : lanes handled by the compute array per beat
//   BEATS          : beats needed to cover one full word
//   BEAT_CNT_W     : width of a beat counter over BEATS
//   lane_t         : one lane word
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package out_buff_pkg;

  localparam int DATA_W         = 32;
  localparam int SFU_IN_LANES   = 32;
  localparam int SFU_CORE_LANES = 8;
  localparam int BEATS          = SFU_IN_LANES / SFU_CORE_LANES;
  localparam int BEAT_CNT_W     = $clog2(BEATS);

  typedef logic [DATA_W-1:0] lane_t;

endpackage : out_buff_pkg

`default_nettype wire

// File: rtl/out_buff.sv
//------------------------------------------------------------------------------
// out_buff
//   Result-side reassembly buffer at the SFU datapath output. Collects four
//   consecutive accepted 8-lane beats and presents them as one 32-lane word
//   with a one-cycle valid pulse. The output bank is separate from the
//   staging registers, so the presented word stays stable while the next
//   group accumulates.
//
//   Ports
//     clk                          : clock, all state on rising edge
//     rstn                         : asynchronous active-low reset
//     enable                       : block enable; low freezes counter/staging
//     in_data_0 .. in_data_7       : input beat lanes
//     in_data_valid                : input beat qualifier
//     out_data_0 .. out_data_31    : assembled output lanes
//     out_data_valid               : one-cycle pulse per assembled word
//
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module out_buff #(
  parameter int DATA_W    = out_buff_pkg::DATA_W,
  // Lane counts must match the flat port list below.
  parameter int IN_LANES  = out_buff_pkg::SFU_CORE_LANES,
  parameter int OUT_LANES = out_buff_pkg::SFU_IN_LANES
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  input  logic [DATA_W-1:0] in_data_4,
  input  logic [DATA_W-1:0] in_data_5,
  input  logic [DATA_W-1:0] in_data_6,
  input  logic [DATA_W-1:0] in_data_7,
  input  logic              in_data_valid,
  output logic [DATA_W-1:0] out_data_0,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [DATA_W-1:0] out_data_3,
  output logic [DATA_W-1:0] out_data_4,
  output logic [DATA_W-1:0] out_data_5,
  output logic [DATA_W-1:0] out_data_6,
  output logic [DATA_W-1:0] out_data_7,
  output logic [DATA_W-1:0] out_data_8,
  output logic [DATA_W-1:0] out_data_9,
  output logic [DATA_W-1:0] out_data_10,
  output logic [DATA_W-1:0] out_data_11,
  output logic [DATA_W-1:0] out_data_12,
  output logic [DATA_W-1:0] out_data_13,
  output logic [DATA_W-1:0] out_data_14,
  output logic [DATA_W-1:0] out_data_15,
  output logic [DATA_W-1:0] out_data_16,
  output logic [DATA_W-1:0] out_data_17,
  output logic [DATA_W-1:0] out_data_18,
  output logic [DATA_W-1:0] out_data_19,
  output logic [DATA_W-1:0] out_data_20,
  output logic [DATA_W-1:0] out_data_21,
  output logic [DATA_W-1:0] out_data_22,
  output logic [DATA_W-1:0] out_data_23,
  output logic [DATA_W-1:0] out_data_24,
  output logic [DATA_W-1:0] out_data_25,
  output logic [DATA_W-1:0] out_data_26,
  output logic [DATA_W-1:0] out_data_27,
  output logic [DATA_W-1:0] out_data_28,
  output logic [DATA_W-1:0] out_data_29,
  output logic [DATA_W-1:0] out_data_30,
  output logic [DATA_W-1:0] out_data_31,
  output logic              out_data_valid
);

  import out_buff_pkg::*;

  localparam int BEATS   = OUT_LANES / IN_LANES;
  localparam int CNT_W   = $clog2(BEATS);
  // Only the first BEATS-1 beats are staged; the last beat goes straight
  // to the output bank on the completing edge.
  localparam int STAGE_N = (BEATS - 1) * IN_LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [DATA_W-1:0] in_lanes [IN_LANES];
  logic [DATA_W-1:0] stage    [STAGE_N];
  logic [DATA_W-1:0] out_word [OUT_LANES];
  logic [CNT_W-1:0]  beat_cnt;
  logic              accept;
  logic              last_beat;

  assign in_lanes[0] = in_data_0;
  assign in_lanes[1] = in_data_1;
  assign in_lanes[2] = in_data_2;
  assign in_lanes[3] = in_data_3;
  assign in_lanes[4] = in_data_4;
  assign in_lanes[5] = in_data_5;
  assign in_lanes[6] = in_data_6;
  assign in_lanes[7] = in_data_7;

  assign accept    = enable & in_data_valid;
  assign last_beat = (beat_cnt == LAST_BEAT);

  // Beat counter: advances only on accepted beats and wraps after the last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Staging: beat b lands in lanes b*IN_LANES .. b*IN_LANES+IN_LANES-1.
  // Constant indices per beat keep the write decode static.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGE_N; i++) begin
        stage[i] <= '0;
      end
    end else if (accept) begin
      for (int b = 0; b < BEATS - 1; b++) begin
        if (beat_cnt == CNT_W'(b)) begin
          for (int k = 0; k < IN_LANES; k++) begin
            stage[b*IN_LANES + k] <= in_lanes[k];
          end
        end
      end
    end
  end

  // Output bank: loaded only on group completion, otherwise holds forever.
  // The valid pulse is recomputed every edge, so it never lasts more than
  // one cycle even when enable drops right after completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < OUT_LANES; i++) begin
        out_word[i] <= '0;
      end
      out_data_valid <= 1'b0;
    end else begin
      out_data_valid <= accept & last_beat;
      if (accept && last_beat) begin
        for (int i = 0; i < STAGE_N; i++) begin
          out_word[i] <= stage[i];
        end
        for (int k = 0; k < IN_LANES; k++) begin
          out_word[STAGE_N + k] <= in_lanes[k];
        end
      end
    end
  end

  assign out_data_0  = out_word[0];
  assign out_data_1  = out_word[1];
  assign out_data_2  = out_word[2];
  assign out_data_3  = out_word[3];
  assign out_data_4  = out_word[4];
  assign out_data_5  = out_word[5];
  assign out_data_6  = out_word[6];
  assign out_data_7  = out_word[7];
  assign out_data_8  = out_word[8];
  assign out_data_9  = out_word[9];
  assign out_data_10 = out_word[10];
  assign out_data_11 = out_word[11];
  assign out_data_12 = out_word[12];
  assign out_data_13 = out_word[13];
  assign out_data_14 = out_word[14];
  assign out_data_15 = out_word[15];
  assign out_data_16 = out_word[16];
  assign out_data_17 = out_word[17];
  assign out_data_18 = out_word[18];
  assign out_data_19 = out_word[19];
  assign out_data_20 = out_word[20];
  assign out_data_21 = out_word[21];
  assign out_data_22 = out_word[22];
  assign out_data_23 = out_word[23];
  assign out_data_24 = out_word[24];
  assign out_data_25 = out_word[25];
  assign out_data_26 = out_word[26];
  assign out_data_27 = out_word[27];
  assign out_data_28 = out_word[28];
  assign out_data_29 = out_word[29];
  assign out_data_30 = out_word[30];
  assign out_data_31 = out_word[31];

endmodule : out_buff

`default_nettype wire
